lcd_fetch: RTL and testbench

- Video fetch scheduler for the LCD path.
- Walks the Screen Base File one pixel line at a time and issues video memory reads on `va` during non-Z80 memory slots.
- Resolves each character's attribute pair to a font byte in LORES0/LORES1/HIRES0/HIRES1, using the `pb0w`..`pb3w` and `sbrw` register outputs.
- Streams attribute-processed pixel bytes to the LCD shifter through a valid/ready handshake.

---
 rtl/lcd_fetch_pkg.sv | 20 ++
 rtl/lcd_attr_decode.sv | 51 +++++
 rtl/lcd_fetch.sv | 147 ++++++++++++++
 tb/tb_lcd_fetch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_fetch_pkg.sv
// lcd_fetch_pkg: shared FSM states, font region thresholds, attribute bits and the attribute address helper
package lcd_fetch_pkg;

  typedef enum logic [2:0] {IDLE, ATTR0, ATTR1, FONT, EMIT, BLANK} state_e;

  localparam logic [9:0] HIRES1_MIN = 10'h300;
  localparam logic [8:0] LORES0_MIN = 9'h1C0;

  localparam int A_HIRES = 5;
  localparam int A_REV   = 4;
  localparam int A_FLASH = 3;
  localparam int A_GREY  = 2;
  localparam int A_UNDER = 1;

  function automatic logic [21:0] attr_addr(input logic [10:0] sbr, input logic [5:0] line,
                                            input logic [6:0] col, input logic odd);
    return {sbr, line[5:3], col, odd};
  endfunction

endpackage

// File: rtl/lcd_attr_decode.sv
// lcd_attr_decode: maps an attribute pair to its font address, glyph width and processed pixel byte (grey via LCD_FETCH_GREY_EN)
module lcd_attr_decode
  import lcd_fetch_pkg::*;
(
  input  logic [7:0]  b0_i,
  input  logic [7:0]  b1_i,
  input  logic [2:0]  l_i,
  input  logic [12:0] pb0_i,
  input  logic [9:0]  pb1_i,
  input  logic [8:0]  pb2_i,
  input  logic [10:0] pb3_i,
  input  logic [7:0]  f_i,
  input  logic        t_1s_i,
  input  logic        t_5ms_i,
  output logic [21:0] font_addr_o,
  output logic        wide_o,
  output logic [7:0]  pix_o
);

  logic       hires;
  logic [9:0] code10;
  logic [8:0] code9;
  logic [7:0] p_base, p_ul, p_rev, p_fl, p_gr;
  logic       unused_bits;

  // font region select and underline/reverse/flash chain
  always_comb begin
    hires = b1_i[A_HIRES];
    code10 = {b1_i[1:0], b0_i};
    code9 = {b1_i[0], b0_i};
    font_addr_o = hires ? (code10 >= HIRES1_MIN ? {pb3_i, code10[7:0], l_i} : {pb2_i, code10, l_i})
                        : (code9 >= LORES0_MIN ? {pb0_i, code9[5:0], l_i} : {pb1_i, code9, l_i});
    p_base = hires ? f_i : {2'b00, f_i[5:0]};
    p_ul = (!hires && b1_i[A_UNDER] && (&l_i)) ? 8'hFF : p_base;
    p_rev = b1_i[A_REV] ? ~p_ul : p_ul;
    p_fl = (b1_i[A_FLASH] && t_1s_i) ? ~p_rev : p_rev;
    wide_o = hires;
  end

`ifdef LCD_FETCH_GREY_EN
  assign p_gr = (b1_i[A_GREY] && t_5ms_i) ? 8'h00 : p_fl;
`else
  logic unused_grey;
  assign unused_grey = t_5ms_i ^ b1_i[A_GREY];
  assign p_gr = p_fl;
`endif

  assign unused_bits = ^b1_i[7:6];
  assign pix_o = hires ? p_gr : {2'b00, p_gr[5:0]};

endmodule

// File: rtl/lcd_fetch.sv
// lcd_fetch: per-line video fetch scheduler feeding the LCD shifter (optional grey attribute via LCD_FETCH_GREY_EN)
module lcd_fetch
  import lcd_fetch_pkg::*;
#(
  parameter int COLS  = 106,
  parameter int LINES = 64
) (
  input  logic        mck,
  input  logic        rin_n,
  input  logic        lcdon,
  input  logic [12:0] pb0w,
  input  logic [9:0]  pb1w,
  input  logic [8:0]  pb2w,
  input  logic [10:0] pb3w,
  input  logic [10:0] sbrw,
  input  logic        t_1s,
  input  logic        t_5ms,
  input  logic        vid_slot,
  output logic [21:0] va,
  input  logic [7:0]  vid_cdo,
  input  logic        line_req,
  input  logic        frame_sync,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic        pix_wide,
  input  logic        pix_ready,
  output logic        line_done,
  output logic        busy
);

  state_e      st_q;
  logic [5:0]  line_q, line_d, line_start;
  logic [6:0]  col_q, col_d;
  logic [12:0] pb0_q;
  logic [9:0]  pb1_q;
  logic [8:0]  pb2_q;
  logic [10:0] pb3_q, sbr_q;
  logic [7:0]  b0_q, b1_q, b1_sel;
  logic [21:0] va_q, font_addr;
  logic [7:0]  pix_data_q, pix;
  logic        pix_valid_q, pix_wide_q, line_done_q, wide, last;

  // b1 is decoded straight from the bus in ATTR1 so the font address is ready on entry to FONT
  lcd_attr_decode u_dec (
    .b0_i(b0_q), .b1_i(b1_sel), .l_i(line_q[2:0]),
    .pb0_i(pb0_q), .pb1_i(pb1_q), .pb2_i(pb2_q), .pb3_i(pb3_q),
    .f_i(vid_cdo), .t_1s_i(t_1s), .t_5ms_i(t_5ms),
    .font_addr_o(font_addr), .wide_o(wide), .pix_o(pix)
  );

  // next column/line values and end-of-line detect
  always_comb begin
    col_d = col_q + 7'd1;
    line_d = (line_q == 6'(LINES - 1)) ? 6'd0 : line_q + 6'd1;
    line_start = frame_sync ? 6'd0 : line_q;
    last = col_q == 7'(COLS - 1);
    b1_sel = (st_q == ATTR1) ? vid_cdo : b1_q;
  end

  // fetch FSM: one slot per memory state, stall in EMIT/BLANK until the shifter accepts
  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      st_q <= IDLE;
      line_q <= '0;
      col_q <= '0;
      pb0_q <= '0;
      pb1_q <= '0;
      pb2_q <= '0;
      pb3_q <= '0;
      sbr_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      va_q <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q <= '0;
      pix_wide_q <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      if (frame_sync) line_q <= '0;
      if (frame_sync && st_q != IDLE) begin
        st_q <= IDLE;
        pix_valid_q <= 1'b0;
      end else begin
        case (st_q)
          IDLE: if (line_req) begin
            pb0_q <= pb0w;
            pb1_q <= pb1w;
            pb2_q <= pb2w;
            pb3_q <= pb3w;
            sbr_q <= sbrw;
            col_q <= '0;
            if (lcdon) begin
              st_q <= ATTR0;
              va_q <= attr_addr(sbrw, line_start, 7'd0, 1'b0);
            end else begin
              st_q <= BLANK;
              pix_valid_q <= 1'b1;
              pix_data_q <= 8'h00;
              pix_wide_q <= 1'b1;
            end
          end
          ATTR0: if (vid_slot) begin
            b0_q <= vid_cdo;
            va_q[0] <= 1'b1;
            st_q <= ATTR1;
          end
          ATTR1: if (vid_slot) begin
            b1_q <= vid_cdo;
            va_q <= font_addr;
            st_q <= FONT;
          end
          FONT: if (vid_slot) begin
            pix_data_q <= pix;
            pix_wide_q <= wide;
            pix_valid_q <= 1'b1;
            st_q <= EMIT;
          end
          EMIT, BLANK: if (pix_ready) begin
            if (last) begin
              st_q <= IDLE;
              pix_valid_q <= 1'b0;
              line_done_q <= 1'b1;
              line_q <= line_d;
            end else begin
              col_q <= col_d;
              if (st_q == EMIT) begin
                st_q <= ATTR0;
                pix_valid_q <= 1'b0;
                va_q <= attr_addr(sbr_q, line_q, col_d, 1'b0);
              end
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign va = va_q;
  assign pix_valid = pix_valid_q;
  assign pix_data = pix_data_q;
  assign pix_wide = pix_wide_q;
  assign line_done = line_done_q;
  assign busy = st_q != IDLE;

endmodule

// File: tb/tb_lcd_fetch.sv
// tb_lcd_fetch: randomized scoreboard bench for lcd_fetch against a behavioural line model
module tb_lcd_fetch;

  localparam int COLS = 106;
  localparam int LINES = 64;

  logic        mck = 1'b0, rin_n = 1'b1, lcdon = 1'b0, t_1s = 1'b0, t_5ms = 1'b0;
  logic        vid_slot = 1'b0, line_req = 1'b0, frame_sync = 1'b0, pix_ready = 1'b0;
  logic [12:0] pb0w = '0;
  logic [9:0]  pb1w = '0;
  logic [8:0]  pb2w = '0;
  logic [10:0] pb3w = '0, sbrw = '0;
  logic [7:0]  vid_cdo = '0;
  logic [21:0] va;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_wide, line_done, busy;

  int checks = 0, errors = 0;
  int cyc = 0, slot_mode = 0, model_line = 0;
  int bytes_in_line = 0, done_cnt = 0;
  bit ready_rand = 0, ready_hold = 0, exp_done = 0, stalled = 0;
  logic [8:0]  stall_data;
  logic [7:0]  mem_ov [int];
  logic [8:0]  exp_px[$], seen_px[$];
  logic [21:0] exp_va[$], seen_va[$];

  lcd_fetch #(.COLS(COLS), .LINES(LINES)) dut (
    .mck(mck), .rin_n(rin_n), .lcdon(lcdon),
    .pb0w(pb0w), .pb1w(pb1w), .pb2w(pb2w), .pb3w(pb3w), .sbrw(sbrw),
    .t_1s(t_1s), .t_5ms(t_5ms), .vid_slot(vid_slot), .va(va), .vid_cdo(vid_cdo),
    .line_req(line_req), .frame_sync(frame_sync),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_wide(pix_wide), .pix_ready(pix_ready),
    .line_done(line_done), .busy(busy)
  );

  always #50 mck = ~mck;

  function automatic logic [7:0] rd(input logic [21:0] a);
    if (mem_ov.exists(int'(a))) return mem_ov[int'(a)];
    return 8'((32'(a) * 32'h9E3779B1) >> 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory answers only on slot cycles; off-slot data is corrupted so an early advance is caught
  task automatic tick();
    @(posedge mck);
    #1;
    cyc++;
    vid_slot = slot_mode == 0 ? 1'b1 : (slot_mode == 1 ? (cyc % 3 != 0) : 1'($urandom_range(1)));
    vid_cdo = vid_slot ? rd(va) : ~rd(va);
    pix_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(1)) : 1'b1);
  endtask

  task automatic randomize_regs();
    pb0w = 13'($urandom);
    pb1w = 10'($urandom);
    pb2w = 9'($urandom);
    pb3w = 11'($urandom);
    sbrw = 11'($urandom);
  endtask

  // reference: expected reads and pixel bytes for one whole line from the current register values
  task automatic push_line();
    int a, b0, b1, code, fa, f, p, l3;
    bit hires;
    l3 = model_line % 8;
    for (int c = 0; c < COLS; c++) begin
      if (!lcdon) exp_px.push_back({1'b1, 8'h00});
      else begin
        a = int'(sbrw) * 2048 + (model_line / 8) * 256 + c * 2;
        b0 = int'(rd(22'(a)));
        b1 = int'(rd(22'(a + 1)));
        hires = b1[5];
        if (hires) begin
          code = (b1 % 4) * 256 + b0;
          fa = code >= 768 ? int'(pb3w) * 2048 + (code % 256) * 8 + l3 : int'(pb2w) * 8192 + code * 8 + l3;
        end else begin
          code = (b1 % 2) * 256 + b0;
          fa = code >= 448 ? int'(pb0w) * 512 + (code % 64) * 8 + l3 : int'(pb1w) * 4096 + code * 8 + l3;
        end
        f = int'(rd(22'(fa)));
        p = hires ? f : f % 64;
        if (!hires && b1[1] && l3 == 7) p = 255;
        if (b1[4]) p = 255 - p;
        if (b1[3] && t_1s) p = 255 - p;
`ifdef LCD_FETCH_GREY_EN
        if (b1[2] && t_5ms) p = 0;
`endif
        p = hires ? p : p % 64;
        exp_va.push_back(22'(a));
        exp_va.push_back(22'(a + 1));
        exp_va.push_back(22'(fa));
        exp_px.push_back({hires, 8'(p)});
      end
    end
  endtask

  // monitor: memory accesses, accepted bytes, stall stability and line_done timing
  always @(negedge mck) if (rin_n) begin
    if (line_done) done_cnt++;
    if (line_done || exp_done) chk("line_done_timing", line_done, exp_done);
    exp_done = 0;
    if (busy && !pix_valid && vid_slot) begin
      seen_va.push_back(va);
      if (exp_va.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_access: va %0h with no read expected", va);
      end else chk("va", va, exp_va.pop_front());
    end
    if (stalled && pix_valid) chk("stall_stable", {pix_wide, pix_data}, stall_data);
    stalled = pix_valid && !pix_ready;
    stall_data = {pix_wide, pix_data};
    if (pix_valid && pix_ready) begin
      seen_px.push_back({pix_wide, pix_data});
      if (exp_px.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_pixel: %0h with none expected", {pix_wide, pix_data});
      end else chk("pixel", {pix_wide, pix_data}, exp_px.pop_front());
      bytes_in_line++;
      if (bytes_in_line == COLS) exp_done = 1;
    end
  end

  task automatic run_line(input bit stall, input bit pokes, input bit sync);
    int start_done, n, stall_left;
    if (sync) model_line = 0;
    push_line();
    seen_va.delete();
    seen_px.delete();
    bytes_in_line = 0;
    start_done = done_cnt;
    stall_left = stall ? 10 : 0;
    line_req = 1;
    frame_sync = sync;
    tick();
    line_req = 0;
    frame_sync = 0;
    n = 0;
    while (done_cnt == start_done && n < 6000) begin
      if (stall_left > 0 && pix_valid) begin
        ready_hold = 1;
        stall_left--;
      end else ready_hold = 0;
      if (pokes && n == 20) randomize_regs();
      line_req = pokes && n == 30;
      tick();
      n++;
    end
    ready_hold = 0;
    line_req = 0;
    tick();
    tick();
    chk("line_done_count", done_cnt - start_done, 1);
    chk("bytes_per_line", bytes_in_line, COLS);
    chk("px_queue_drained", exp_px.size(), 0);
    chk("va_queue_drained", exp_va.size(), 0);
    chk("idle_after_line", busy, 0);
    model_line = (model_line + 1) % LINES;
  endtask

  initial begin
    logic [21:0] va_before;
    logic [10:0] sbr_cap;
    int start_done, n;
    #10 rin_n = 0;
    repeat (3) tick();
    chk("rst_va", va, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_wide", pix_wide, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_busy", busy, 0);
    rin_n = 1;
    tick();

    // line 0: hires glyph in HIRES1 with reverse
    lcdon = 1;
    sbrw = 11'h123;
    pb3w = 11'h7FF;
    mem_ov[int'(sbrw) * 2048] = 8'h05;
    mem_ov[int'(sbrw) * 2048 + 1] = 8'h33;
    mem_ov[22'h3FF828] = 8'h0F;
    run_line(0, 0, 0);
    chk("hires_font_va", seen_va[2], 22'h3FF828);
    chk("hires_pixel", seen_px[0], 9'h1F0);

    // lines 1..6 blank: no reads and va must not move
    lcdon = 0;
    for (int i = 0; i < 6; i++) begin
      va_before = va;
      run_line(0, 0, 0);
      chk("blank_va_hold", va, va_before);
    end

    // line 7: lores glyph from LORES1 with underline
    mem_ov.delete();
    lcdon = 1;
    sbrw = 11'h010;
    pb1w = 10'h3C0;
    mem_ov[32'h8000] = 8'h41;
    mem_ov[32'h8001] = 8'h02;
    run_line(0, 0, 0);
    chk("lores_font_va", seen_va[2], 22'h3C020F);
    chk("lores_pixel", seen_px[0], 9'h03F);

    // line 8 blank, line 9 checks attribute addressing at col 3
    mem_ov.delete();
    lcdon = 0;
    run_line(0, 0, 0);
    lcdon = 1;
    run_line(0, 0, 0);
    chk("attr0_va_col3", seen_va[9], 22'h008106);
    chk("attr1_va_col3", seen_va[10], 22'h008107);

    // randomized lines: slot patterns, backpressure, mid-line register writes, ignored line_req
    ready_rand = 1;
    for (int i = 0; i < 12; i++) begin
      randomize_regs();
      lcdon = ($urandom_range(4) != 0);
      t_1s = 1'($urandom_range(1));
      t_5ms = 1'($urandom_range(1));
      slot_mode = i % 3;
      run_line(i % 3 == 1, 1, 0);
    end

    // abort mid-line at col 50
    randomize_regs();
    lcdon = 1;
    slot_mode = 2;
    push_line();
    bytes_in_line = 0;
    start_done = done_cnt;
    line_req = 1;
    tick();
    line_req = 0;
    n = 0;
    while (bytes_in_line < 50 && n < 6000) begin
      tick();
      n++;
    end
    chk("abort_reached_col50", bytes_in_line, 50);
    frame_sync = 1;
    tick();
    frame_sync = 0;
    chk("abort_idle", busy, 0);
    chk("abort_no_valid", pix_valid, 0);
    exp_px.delete();
    exp_va.delete();
    bytes_in_line = 0;
    model_line = 0;
    repeat (5) tick();
    chk("abort_no_line_done", done_cnt - start_done, 0);
    sbr_cap = sbrw;
    run_line(0, 0, 0);
    chk("after_abort_line0_col0", seen_va[0], 22'({sbr_cap, 11'd0}));

    // frame_sync together with line_req starts at line 0
    randomize_regs();
    sbr_cap = sbrw;
    run_line(0, 0, 1);
    chk("sync_req_line0", seen_va[0], 22'({sbr_cap, 11'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
